// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline controller: controller state encoding,
// the per-stage stall patterns and the stall priority encoder.
// stall bit order: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB,
// where 1 means the register holds its value (Stop).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // The requesting stage and everything upstream of it stop; the first running
  // stage downstream therefore receives a bubble.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'b00,
    CTRL_PEND  = 2'b01,
    CTRL_DRAIN = 2'b10
  } ctrl_state_e;

  // Highest-priority (furthest downstream) request wins.
  function automatic logic [5:0] stall_encode(input logic req_mem,
                                              input logic req_ex,
                                              input logic req_id,
                                              input logic req_if);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the pipeline stages and the pipeline controller.
//   stallreq_if/id/ex/mem : per-stage stall requests (pipeline -> ctrl)
//   excp_valid/excp_target: exception/eret redirect request from MEM
//   stall[5:0]            : per-register stop vector (ctrl -> pipeline)
//   flush, new_pc         : clear all pipeline registers and redirect the PC
//   drop_fetch            : IF must discard the returning fetch response
// master = pipeline side, slave = controller side.
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int PC_W = 32
);
  logic            stallreq_if;
  logic            stallreq_id;
  logic            stallreq_ex;
  logic            stallreq_mem;
  logic            excp_valid;
  logic [PC_W-1:0] excp_target;
  logic [5:0]      stall;
  logic            flush;
  logic [PC_W-1:0] new_pc;
  logic            drop_fetch;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excp_valid, excp_target,
    input  stall, flush, new_pc, drop_fetch
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_valid, excp_target,
    output stall, flush, new_pc, drop_fetch
  );
endinterface

// File: rtl/pipe_ctrl_perf_counter.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_perf_counter
// Event counter, +1 per clock edge with i_inc high. SATURATE=1 holds at
// all-ones, SATURATE=0 wraps modulo 2^W.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   i_inc      : count enable
//   o_count    : current count (registered)
// -----------------------------------------------------------------------------
module pipe_ctrl_perf_counter #(
  parameter int W        = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = SATURATE && (&r_count);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline controller. Arbitrates stage stall requests into the stall
// vector, issues flush/new_pc redirects for exceptions (deferring them while
// MEM is busy), flags in-flight fetches to be dropped after a flush, and keeps
// stall/flush performance counters.
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : pipe_ctrl_if.slave (stall requests, exception, stall/flush)
//   stall_cycles : cycles with stall != 0 (saturating)
//   flush_count  : flush pulses (wrapping)
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipe_ctrl_if.slave             bus,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  ctrl_state_e     r_state;
  ctrl_state_e     w_next_state;
  logic [PC_W-1:0] r_target;
  logic            w_latch_target;
  logic            w_flush;
  logic [PC_W-1:0] w_new_pc;
  logic            w_drop;
  logic [5:0]      w_stall_req;
  logic [5:0]      w_stall;

  assign w_stall_req = stall_encode(bus.stallreq_mem, bus.stallreq_ex,
                                    bus.stallreq_id, bus.stallreq_if);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= CTRL_RUN;
      r_target <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_latch_target) r_target <= bus.excp_target;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_latch_target = 1'b0;
    w_flush        = 1'b0;
    w_new_pc       = '0;
    w_drop         = 1'b0;
    unique case (r_state)
      CTRL_RUN, CTRL_DRAIN: begin
        if (r_state == CTRL_DRAIN) begin
          w_drop = 1'b1;
          // The response returning in the cycle stallreq_if drops is the last
          // one to discard.
          if (!bus.stallreq_if) w_next_state = CTRL_RUN;
        end
        if (bus.excp_valid) begin
          if (bus.stallreq_mem) begin
            // MEM still owns the access; defer the redirect until it finishes.
            w_latch_target = 1'b1;
            w_next_state   = CTRL_PEND;
          end else begin
            w_flush      = 1'b1;
            w_new_pc     = bus.excp_target;
            w_next_state = bus.stallreq_if ? CTRL_DRAIN : CTRL_RUN;
          end
        end
      end
      CTRL_PEND: begin
        // New exceptions are ignored here: the oldest one wins.
        if (!bus.stallreq_mem) begin
          w_flush      = 1'b1;
          w_new_pc     = r_target;
          w_next_state = bus.stallreq_if ? CTRL_DRAIN : CTRL_RUN;
        end
      end
      default: w_next_state = CTRL_RUN;
    endcase
  end

  // A flushing cycle clears every register, so nothing may be held.
  assign w_stall = (reset || w_flush) ? STALL_NONE : w_stall_req;

  assign bus.stall      = w_stall;
  assign bus.flush      = !reset && w_flush;
  assign bus.new_pc     = reset ? '0 : w_new_pc;
  assign bus.drop_fetch = !reset && w_drop;

  pipe_ctrl_perf_counter #(
    .W        (STALL_CNT_W),
    .SATURATE (1'b1)
  ) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_stall != STALL_NONE),
    .o_count (stall_cycles)
  );

  pipe_ctrl_perf_counter #(
    .W        (FLUSH_CNT_W),
    .SATURATE (1'b0)
  ) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (bus.flush),
    .o_count (flush_count)
  );

endmodule
